// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with clock deglitcher, timeout, error pulses and FWFT event FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_W  = 16,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               enable_rcv,
    input  logic               kb_or_mouse,
    input  logic               ps2clk_ext,
    input  logic               ps2data_ext,
    input  logic               rd_en,
    output logic [9:0]         dout,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count,
    output logic               overflow,
    output logic               parity_err,
    output logic               frame_err,
    output logic               timeout_err
);

    localparam int FCW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            filt_q, filt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic            fe_q, fe_d;

    state_t          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            ext_q, ext_d, rel_q, rel_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic            perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
    logic            wr_en;
    logic [9:0]      wr_data;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;
    logic               do_wr, do_rd;

    // Filtered level flips only after FILTER_LEN consecutive samples disagree with it
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        fe_d   = 1'b0;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
            fe_d   = filt_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fe_q     <= 1'b0;
        end else begin
            clk_s1_q <= ps2clk_ext;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2data_ext;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fe_q     <= fe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        tmo_d    = tmo_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        terr_d   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = {ext_q, rel_q, shift_q};
        if (!enable_rcv) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end else if (fe_q) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    if ((^shift_q) ^ dat_s2_q) begin
                        state_d = S_STOP;
                    end else begin
                        perr_d  = 1'b1;
                        ext_d   = 1'b0;
                        rel_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end else if (kb_or_mouse) begin
                        wr_en   = 1'b1;
                        wr_data = {2'b00, shift_q};
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        rel_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (&tmo_q) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                terr_d  = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            tmo_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            tmo_q    <= tmo_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            terr_q   <= terr_d;
        end
    end

    // A read frees a slot in the same cycle, so a full FIFO still accepts a concurrent write
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk_sys) begin
        if (do_wr) mem[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en && !do_wr) ovf_q <= 1'b1;
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == (FIFO_AW+1)'(DEPTH));
    assign count       = count_q;
    assign dout        = empty ? 10'h000 : mem[rptr_q];
    assign overflow    = ovf_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

    localparam int H = 40;

    logic       clk = 1'b0;
    logic       rst_n, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext;
    logic       rd_en = 1'b0;
    logic [9:0] dout;
    logic       empty, full, overflow, parity_err, frame_err, timeout_err;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_par = 0, n_frm = 0, n_to = 0;
    int t_last_fall = 0, t_nonempty = 0, t_to = 0;
    logic drain = 1'b0;
    logic empty_prev = 1'b1;
    logic [9:0] exp_q [$];

    ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_W(8), .FIFO_AW(3)) dut (
        .clk_sys(clk), .rst_n(rst_n), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
        .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .count(count), .overflow(overflow),
        .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops the FIFO whenever draining is allowed and compares the head
    always @(negedge clk) begin
        if (drain && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got %0h expected none", dout);
            end else begin
                chk("fifo_entry", {22'd0, dout}, {22'd0, exp_q.pop_front()});
            end
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (parity_err) n_par++;
        if (frame_err) n_frm++;
        if (timeout_err) begin
            n_to++;
            t_to = cyc;
        end
        if (empty_prev && !empty) t_nonempty = cyc;
        empty_prev = empty;
    end

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits,
                              input int gbit, input int glen);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2data_ext = f[i];
            if (i == gbit) begin
                repeat (10) @(negedge clk);
                ps2clk_ext = 1'b0;
                repeat (glen) @(negedge clk);
                ps2clk_ext = 1'b1;
                repeat (H - 10 - glen) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            ps2clk_ext = 1'b0;
            t_last_fall = cyc;
            repeat (H) @(negedge clk);
            ps2clk_ext = 1'b1;
        end
        ps2data_ext = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1, 0);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((!empty || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        int p0, f0, t0;
        rst_n = 1'b0;
        enable_rcv = 1'b1;
        kb_or_mouse = 1'b0;
        ps2clk_ext = 1'b1;
        ps2data_ext = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_dout", {22'd0, dout}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h1C);
        chk("make_latency_ok", {31'd0, (t_nonempty - t_last_fall >= 9) && (t_nonempty - t_last_fall <= 14)}, 32'd1);
        chk("make_empty", {31'd0, empty}, 32'd0);
        chk("make_count", {28'd0, count}, 32'd1);
        chk("make_dout", {22'd0, dout}, 32'h01C);
        exp_q.push_back(10'h01C);
        drain = 1'b1;
        wait_empty("make_drained");

        exp_q.push_back(10'h374);
        exp_q.push_back(10'h01C);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        send(8'h1C);
        wait_empty("prefix_drained");

        p0 = n_par;
        send_frame(8'h1C, 1'b1, 11, -1, 0);
        chk("parity_pulse", n_par - p0, 32'd1);
        chk("parity_empty", {31'd0, empty}, 32'd1);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        wait_empty("after_parity_drained");

        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11, 1, 7);
        wait_empty("glitch7_drained");
        p0 = n_par;
        f0 = n_frm;
        send_frame(8'h1C, 1'b0, 11, 1, 8);
        chk("glitch8_frame_err", n_frm - f0, 32'd1);
        chk("glitch8_no_parity", n_par - p0, 32'd0);
        chk("glitch8_empty", {31'd0, empty}, 32'd1);

        drain = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(10'(i));
            send(8'(i));
        end
        chk("fill_count", {28'd0, count}, 32'd8);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_overflow", {31'd0, overflow}, 32'd1);
        drain = 1'b1;
        wait_empty("fill_drained");
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        t0 = n_to;
        send_frame(8'h1C, 1'b0, 5, -1, 0);
        repeat (300) @(negedge clk);
        chk("timeout_pulse", n_to - t0, 32'd1);
        chk("timeout_delay_ok", {31'd0, (t_to - t_last_fall >= 262) && (t_to - t_last_fall <= 272)}, 32'd1);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        wait_empty("after_timeout_drained");

        kb_or_mouse = 1'b1;
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h0E0);
        send(8'hF0);
        send(8'hE0);
        wait_empty("mouse_drained");
        kb_or_mouse = 1'b0;

        p0 = n_par;
        f0 = n_frm;
        t0 = n_to;
        send_frame(8'h1C, 1'b0, 5, -1, 0);
        enable_rcv = 1'b0;
        repeat (5) @(negedge clk);
        enable_rcv = 1'b1;
        repeat (300) @(negedge clk);
        chk("disable_no_errors", (n_par - p0) + (n_frm - f0) + (n_to - t0), 32'd0);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        wait_empty("after_disable_drained");

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_clears_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
